// File: rtl/adjacency_builder.sv
// adjacency_builder
// Builds per-vertex neighbour lists from a polygon mesh held in object RAM.
// Clears every list count, then walks each face edge by edge and inserts
// each endpoint into the other endpoint's list in neighbour RAM.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   start                      begin a pass (sampled only in IDLE)
//   vertex_count, face_count   mesh sizes, stable while busy
//   RAM_OBJ_*                  object RAM port (read-only use)
//   RAM_NBR_*                  neighbour RAM port
//   busy, done                 pass in progress / one-cycle end pulse
//   overflow, err_index        sticky flags, cleared by start
//
// Build option: define ADJ_DEDUP_EN to scan each list before appending so
// that every undirected edge appears once per list.  Without it the scan is
// omitted and a shared edge appears once per incident face.
//
// state    | meaning
// IDLE     | waiting for start
// CLEAR    | zeroing list counts, one vertex per cycle
// FACE_RD  | reading the current face's vertex indices
// EDGE_SEL | picking the next (list, candidate) pair or the next face
// CNT_RD   | reading the target list count
// SCAN     | comparing existing entries with the candidate
// APPEND   | writing the candidate, or dropping it when the list is full
// CNT_WR   | writing the incremented count
// DONE     | done pulse, returns to IDLE
module adjacency_builder #(
    parameter int ADDR_W     = 9,
    parameter int MAX_NBR    = 10,
    parameter int FACE_VERTS = 3,
    parameter int VERT_WORDS = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [31:0]       vertex_count,
    input  logic [31:0]       face_count,
    output logic              RAM_OBJ_EN,
    output logic [3:0]        RAM_OBJ_WE,
    output logic [ADDR_W-1:0] RAM_OBJ_A,
    output logic [31:0]       RAM_OBJ_Di,
    input  logic [31:0]       RAM_OBJ_Do,
    output logic              RAM_NBR_EN,
    output logic [3:0]        RAM_NBR_WE,
    output logic [ADDR_W-1:0] RAM_NBR_A,
    output logic [31:0]       RAM_NBR_Di,
    input  logic [31:0]       RAM_NBR_Do,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic              err_index
);
    localparam int unsigned   REC    = MAX_NBR + 1;
    localparam int            EW     = $clog2(FACE_VERTS);
    localparam logic [EW-1:0] E_LAST = EW'(FACE_VERTS - 1);
    localparam logic [31:0]   MAXN   = 32'(MAX_NBR);

    typedef enum logic [3:0] {
        IDLE, CLEAR, FACE_RD, EDGE_SEL, CNT_RD, SCAN, APPEND, CNT_WR, DONE
    } state_t;

    state_t        state;
    logic          ph;          // 0: read in flight, 1: read data valid this cycle
    logic [31:0]   clr_v;
    logic [31:0]   obj_ptr;     // faces are contiguous, so one running pointer suffices
    logic [31:0]   faces_left;
    logic [EW-1:0] rd_j;
    logic          bad_acc;
    logic [31:0]   idx [FACE_VERTS];
    logic [EW-1:0] e_idx;
    logic          side;        // 0: insert b into list(a), 1: insert a into list(b)
    logic          edges_done;
    logic [31:0]   tgt_base;
    logic [31:0]   cand;
    logic [31:0]   cnt;
`ifdef ADJ_DEDUP_EN
    logic [31:0]   slot;
`endif

    logic [EW-1:0] e_nxt;
    logic [31:0]   va, vb, tgt_v;
    logic          face_bad;

    always_comb begin
        e_nxt    = (e_idx == E_LAST) ? '0 : e_idx + 1'b1;
        va       = idx[e_idx];
        vb       = idx[e_nxt];
        tgt_v    = side ? vb : va;
        face_bad = bad_acc | (RAM_OBJ_Do >= vertex_count);
    end

    // Next {edges_done, e_idx, side} after finishing one insertion attempt.
    function automatic logic [EW+1:0] step(input logic [EW-1:0] e, input logic s);
        logic [EW-1:0] e_inc;
        e_inc = e + 1'b1;
        if (!s)
            return {1'b0, e, 1'b1};
        else if (e == E_LAST)
            return {1'b1, e, 1'b0};
        else
            return {1'b0, e_inc, 1'b0};
    endfunction

    assign RAM_OBJ_WE = 4'h0;
    assign RAM_OBJ_Di = 32'h0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            ph         <= 1'b0;
            clr_v      <= '0;
            obj_ptr    <= '0;
            faces_left <= '0;
            rd_j       <= '0;
            bad_acc    <= 1'b0;
            for (int i = 0; i < FACE_VERTS; i++) idx[i] <= '0;
            e_idx      <= '0;
            side       <= 1'b0;
            edges_done <= 1'b0;
            tgt_base   <= '0;
            cand       <= '0;
            cnt        <= '0;
`ifdef ADJ_DEDUP_EN
            slot       <= '0;
`endif
            RAM_OBJ_EN <= 1'b0;
            RAM_OBJ_A  <= '0;
            RAM_NBR_EN <= 1'b0;
            RAM_NBR_WE <= 4'h0;
            RAM_NBR_A  <= '0;
            RAM_NBR_Di <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            overflow   <= 1'b0;
            err_index  <= 1'b0;
        end else begin
            RAM_OBJ_EN <= 1'b0;
            RAM_NBR_EN <= 1'b0;
            RAM_NBR_WE <= 4'h0;
            done       <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    overflow  <= 1'b0;
                    err_index <= 1'b0;
                    busy      <= 1'b1;
                    obj_ptr   <= 32'd2 + 32'(VERT_WORDS) * vertex_count;
                    state     <= CLEAR;
                    if (vertex_count != 32'd0) begin
                        RAM_NBR_EN <= 1'b1;
                        RAM_NBR_WE <= 4'hF;
                        RAM_NBR_A  <= '0;
                        RAM_NBR_Di <= '0;
                        clr_v      <= 32'd1;
                    end else begin
                        clr_v      <= 32'd0;
                    end
                end
                CLEAR: begin
                    if (clr_v < vertex_count) begin
                        RAM_NBR_EN <= 1'b1;
                        RAM_NBR_WE <= 4'hF;
                        RAM_NBR_A  <= ADDR_W'(clr_v * REC);
                        RAM_NBR_Di <= '0;
                        clr_v      <= clr_v + 32'd1;
                    end else if (face_count == 32'd0 || vertex_count == 32'd0) begin
                        state <= DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        faces_left <= face_count - 32'd1;
                        RAM_OBJ_EN <= 1'b1;
                        RAM_OBJ_A  <= ADDR_W'(obj_ptr);
                        obj_ptr    <= obj_ptr + 32'd1;
                        rd_j       <= '0;
                        bad_acc    <= 1'b0;
                        ph         <= 1'b0;
                        state      <= FACE_RD;
                    end
                end
                FACE_RD: begin
                    if (!ph) begin
                        ph <= 1'b1;
                    end else begin
                        ph        <= 1'b0;
                        idx[rd_j] <= RAM_OBJ_Do;
                        if (rd_j == E_LAST) begin
                            e_idx      <= '0;
                            side       <= 1'b0;
                            edges_done <= face_bad;   // a bad face contributes no edges
                            if (face_bad) err_index <= 1'b1;
                            state      <= EDGE_SEL;
                        end else begin
                            rd_j       <= rd_j + 1'b1;
                            bad_acc    <= face_bad;
                            RAM_OBJ_EN <= 1'b1;
                            RAM_OBJ_A  <= ADDR_W'(obj_ptr);
                            obj_ptr    <= obj_ptr + 32'd1;
                        end
                    end
                end
                EDGE_SEL: begin
                    if (edges_done) begin
                        if (faces_left == 32'd0) begin
                            state <= DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            faces_left <= faces_left - 32'd1;
                            RAM_OBJ_EN <= 1'b1;
                            RAM_OBJ_A  <= ADDR_W'(obj_ptr);
                            obj_ptr    <= obj_ptr + 32'd1;
                            rd_j       <= '0;
                            bad_acc    <= 1'b0;
                            ph         <= 1'b0;
                            state      <= FACE_RD;
                        end
                    end else if (va == vb) begin
                        // degenerate edge: skip both directions
                        {edges_done, e_idx, side} <= step(e_idx, 1'b1);
                    end else begin
                        tgt_base   <= tgt_v * REC;
                        cand       <= side ? va : vb;
                        RAM_NBR_EN <= 1'b1;
                        RAM_NBR_A  <= ADDR_W'(tgt_v * REC);
                        ph         <= 1'b0;
                        state      <= CNT_RD;
                    end
                end
                CNT_RD: begin
                    if (!ph) begin
                        ph <= 1'b1;
                    end else begin
                        ph  <= 1'b0;
                        cnt <= RAM_NBR_Do;
`ifdef ADJ_DEDUP_EN
                        if (RAM_NBR_Do == 32'd0) begin
                            state <= APPEND;
                        end else begin
                            slot       <= 32'd1;
                            RAM_NBR_EN <= 1'b1;
                            RAM_NBR_A  <= ADDR_W'(tgt_base + 32'd1);
                            state      <= SCAN;
                        end
`else
                        state <= APPEND;
`endif
                    end
                end
`ifdef ADJ_DEDUP_EN
                SCAN: begin
                    if (!ph) begin
                        ph <= 1'b1;
                    end else begin
                        ph <= 1'b0;
                        if (RAM_NBR_Do == cand) begin
                            {edges_done, e_idx, side} <= step(e_idx, side);
                            state <= EDGE_SEL;
                        end else if (slot == cnt) begin
                            state <= APPEND;
                        end else begin
                            slot       <= slot + 32'd1;
                            RAM_NBR_EN <= 1'b1;
                            RAM_NBR_A  <= ADDR_W'(tgt_base + slot + 32'd1);
                        end
                    end
                end
`endif
                APPEND: begin
                    if (cnt >= MAXN) begin
                        overflow <= 1'b1;
                        {edges_done, e_idx, side} <= step(e_idx, side);
                        state    <= EDGE_SEL;
                    end else begin
                        RAM_NBR_EN <= 1'b1;
                        RAM_NBR_WE <= 4'hF;
                        RAM_NBR_A  <= ADDR_W'(tgt_base + cnt + 32'd1);
                        RAM_NBR_Di <= cand;
                        state      <= CNT_WR;
                    end
                end
                CNT_WR: begin
                    RAM_NBR_EN <= 1'b1;
                    RAM_NBR_WE <= 4'hF;
                    RAM_NBR_A  <= ADDR_W'(tgt_base);
                    RAM_NBR_Di <= cnt + 32'd1;
                    {edges_done, e_idx, side} <= step(e_idx, side);
                    state      <= EDGE_SEL;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_adjacency_builder.sv
module tb_adjacency_builder;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start1, start2;
    logic [31:0] vertex_count, face_count;

    logic        obj_en1, obj_en2, nbr_en1, nbr_en2;
    logic [3:0]  obj_we1, obj_we2, nbr_we1, nbr_we2;
    logic [8:0]  obj_a1, obj_a2, nbr_a1, nbr_a2;
    logic [31:0] obj_di1, obj_di2, nbr_di1, nbr_di2;
    logic [31:0] obj_do1, obj_do2, nbr_do1, nbr_do2;
    logic        busy1, busy2, done1, done2, ovf1, ovf2, err1, err2;

    logic [31:0] obj_mem  [512];
    logic [31:0] nbr_mem1 [512];
    logic [31:0] nbr_mem2 [512];
    logic        bd_obj_we, bd_nbr_we1;
    logic [8:0]  bd_a;
    logic [31:0] bd_d;

    int passed = 0;
    int total  = 0;

`ifdef ADJ_DEDUP_EN
    localparam int EXP_SHARED = 3;
`else
    localparam int EXP_SHARED = 4;
`endif

    always #5 clk = ~clk;

    adjacency_builder u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1),
        .vertex_count(vertex_count), .face_count(face_count),
        .RAM_OBJ_EN(obj_en1), .RAM_OBJ_WE(obj_we1), .RAM_OBJ_A(obj_a1),
        .RAM_OBJ_Di(obj_di1), .RAM_OBJ_Do(obj_do1),
        .RAM_NBR_EN(nbr_en1), .RAM_NBR_WE(nbr_we1), .RAM_NBR_A(nbr_a1),
        .RAM_NBR_Di(nbr_di1), .RAM_NBR_Do(nbr_do1),
        .busy(busy1), .done(done1), .overflow(ovf1), .err_index(err1)
    );

    adjacency_builder #(.MAX_NBR(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2),
        .vertex_count(vertex_count), .face_count(face_count),
        .RAM_OBJ_EN(obj_en2), .RAM_OBJ_WE(obj_we2), .RAM_OBJ_A(obj_a2),
        .RAM_OBJ_Di(obj_di2), .RAM_OBJ_Do(obj_do2),
        .RAM_NBR_EN(nbr_en2), .RAM_NBR_WE(nbr_we2), .RAM_NBR_A(nbr_a2),
        .RAM_NBR_Di(nbr_di2), .RAM_NBR_Do(nbr_do2),
        .busy(busy2), .done(done2), .overflow(ovf2), .err_index(err2)
    );

    // synchronous RAMs: read data appears the cycle after the address is captured
    always @(posedge clk) begin
        if (bd_obj_we) obj_mem[bd_a] <= bd_d;
        if (obj_en1) obj_do1 <= obj_mem[obj_a1];
        if (obj_en2) obj_do2 <= obj_mem[obj_a2];
    end

    always @(posedge clk) begin
        if (bd_nbr_we1) nbr_mem1[bd_a] <= bd_d;
        if (nbr_en1) begin
            if (nbr_we1 == 4'hF) nbr_mem1[nbr_a1] <= nbr_di1;
            nbr_do1 <= nbr_mem1[nbr_a1];
        end
    end

    always @(posedge clk) begin
        if (nbr_en2) begin
            if (nbr_we2 == 4'hF) nbr_mem2[nbr_a2] <= nbr_di2;
            nbr_do2 <= nbr_mem2[nbr_a2];
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic bit in_l1(input int base, input int n, input logic [31:0] v);
        bit f = 1'b0;
        for (int s = 1; s <= n && s <= 10; s++)
            if (nbr_mem1[9'(base + s)] == v) f = 1'b1;
        return f;
    endfunction

    task automatic bd_write(input int a, input logic [31:0] d, input bit to_nbr);
        bd_a = 9'(a);
        bd_d = d;
        if (to_nbr) bd_nbr_we1 = 1'b1; else bd_obj_we = 1'b1;
        @(negedge clk);
        bd_obj_we  = 1'b0;
        bd_nbr_we1 = 1'b0;
    endtask

    task automatic load_face(input int vc, input int f, input int i0, input int i1, input int i2);
        int base;
        base = 2 + 3 * vc + 3 * f;
        bd_write(base,     32'(i0), 1'b0);
        bd_write(base + 1, 32'(i1), 1'b0);
        bd_write(base + 2, 32'(i2), 1'b0);
    endtask

    // Pulses start for one cycle, then waits (bounded) for done plus three more cycles.
    task automatic run_pass(input bit sel, output int pulses, output bit busy_first);
        int post;
        @(negedge clk);
        if (sel) start2 = 1'b1; else start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        start2 = 1'b0;
        busy_first = sel ? busy2 : busy1;
        pulses = 0;
        post = -1;
        for (int c = 0; c < 3000 && post != 0; c++) begin
            if (sel ? done2 : done1) begin
                pulses++;
                if (post < 0) post = 3;
            end
            if (post > 0) post--;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({busy1, done1, ovf1, err1} !== 4'b0000)
            $display("FAIL reset_flags: got %b want 0000", {busy1, done1, ovf1, err1});
        else passed++;
        total++;
        if ({obj_en1, obj_we1, obj_a1, obj_di1} !== '0)
            $display("FAIL reset_obj_port: en=%b we=%h a=%h di=%h want all 0", obj_en1, obj_we1, obj_a1, obj_di1);
        else passed++;
        total++;
        if ({nbr_en1, nbr_we1, nbr_a1, nbr_di1} !== '0)
            $display("FAIL reset_nbr_port: en=%b we=%h a=%h di=%h want all 0", nbr_en1, nbr_we1, nbr_a1, nbr_di1);
        else passed++;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_triangle;
        int pulses;
        bit bf;
        vertex_count = 3;
        face_count   = 1;
        load_face(3, 0, 0, 1, 2);
        run_pass(1'b0, pulses, bf);
        total++;
        if (pulses != 1) $display("FAIL tri_done_pulses: got %0d want 1", pulses); else passed++;
        total++;
        if (bf !== 1'b1) $display("FAIL tri_busy_after_start: got %b want 1", bf); else passed++;
        total++;
        if ({busy1, ovf1, err1} !== 3'b000)
            $display("FAIL tri_flags: busy/ovf/err got %b want 000", {busy1, ovf1, err1});
        else passed++;
        total++;
        if ({nbr_mem1[0], nbr_mem1[11], nbr_mem1[22]} !== {32'd2, 32'd2, 32'd2})
            $display("FAIL tri_counts: got %0d %0d %0d want 2 2 2", nbr_mem1[0], nbr_mem1[11], nbr_mem1[22]);
        else passed++;
        total++;
        if (!(in_l1(0, 2, 1) && in_l1(0, 2, 2) && in_l1(11, 2, 0) && in_l1(11, 2, 2) &&
              in_l1(22, 2, 0) && in_l1(22, 2, 1)))
            $display("FAIL tri_lists: got L0=%0d,%0d L1=%0d,%0d L2=%0d,%0d want {1,2} {0,2} {0,1}",
                     nbr_mem1[1], nbr_mem1[2], nbr_mem1[12], nbr_mem1[13], nbr_mem1[23], nbr_mem1[24]);
        else passed++;
    endtask

    task automatic test_shared_edge;
        int pulses;
        bit bf;
        vertex_count = 4;
        face_count   = 2;
        load_face(4, 0, 0, 1, 2);
        load_face(4, 1, 0, 2, 3);
        run_pass(1'b0, pulses, bf);
        total++;
        if (pulses != 1) $display("FAIL shared_done_pulses: got %0d want 1", pulses); else passed++;
        total++;
        if (nbr_mem1[0] !== 32'(EXP_SHARED) || nbr_mem1[22] !== 32'(EXP_SHARED))
            $display("FAIL shared_counts: count0=%0d count2=%0d want %0d", nbr_mem1[0], nbr_mem1[22], EXP_SHARED);
        else passed++;
        total++;
        if (nbr_mem1[11] !== 32'd2 || nbr_mem1[33] !== 32'd2)
            $display("FAIL shared_counts13: count1=%0d count3=%0d want 2", nbr_mem1[11], nbr_mem1[33]);
        else passed++;
        total++;
        if (!(in_l1(0, EXP_SHARED, 1) && in_l1(0, EXP_SHARED, 2) && in_l1(0, EXP_SHARED, 3)))
            $display("FAIL shared_list0: got %0d,%0d,%0d want {1,2,3}", nbr_mem1[1], nbr_mem1[2], nbr_mem1[3]);
        else passed++;
        total++;
        if (!(in_l1(22, EXP_SHARED, 0) && in_l1(22, EXP_SHARED, 1) && in_l1(22, EXP_SHARED, 3)))
            $display("FAIL shared_list2: got %0d,%0d,%0d want {0,1,3}", nbr_mem1[23], nbr_mem1[24], nbr_mem1[25]);
        else passed++;
        total++;
        if ({ovf1, err1} !== 2'b00) $display("FAIL shared_flags: ovf/err got %b want 00", {ovf1, err1}); else passed++;
    endtask

    task automatic test_overflow;
        int pulses;
        bit bf;
        vertex_count = 4;
        face_count   = 2;
        run_pass(1'b1, pulses, bf);
        total++;
        if (pulses != 1) $display("FAIL ovf_done_pulses: got %0d want 1", pulses); else passed++;
        total++;
        if ({nbr_mem2[0], nbr_mem2[1], nbr_mem2[2]} !== {32'd2, 32'd1, 32'd2})
            $display("FAIL ovf_list0: count=%0d slots=%0d,%0d want 2 {1,2}", nbr_mem2[0], nbr_mem2[1], nbr_mem2[2]);
        else passed++;
        total++;
        if (nbr_mem2[6] !== 32'd2) $display("FAIL ovf_count2: got %0d want 2", nbr_mem2[6]); else passed++;
        total++;
        if ({ovf2, err2, busy2} !== 3'b100)
            $display("FAIL ovf_flags: ovf/err/busy got %b want 100", {ovf2, err2, busy2});
        else passed++;
        total++;
        if ({obj_we2, obj_di2} !== '0)
            $display("FAIL ovf_obj_readonly: we=%h di=%h want 0", obj_we2, obj_di2);
        else passed++;
    endtask

    task automatic test_bad_index;
        int pulses;
        bit bf;
        vertex_count = 3;
        face_count   = 1;
        load_face(3, 0, 0, 1, 7);
        bd_write(0,  32'h55, 1'b1);
        bd_write(11, 32'h55, 1'b1);
        bd_write(22, 32'h55, 1'b1);
        run_pass(1'b0, pulses, bf);
        total++;
        if (pulses != 1) $display("FAIL bad_done_pulses: got %0d want 1", pulses); else passed++;
        total++;
        if ({err1, ovf1} !== 2'b10) $display("FAIL bad_flags: err/ovf got %b want 10", {err1, ovf1}); else passed++;
        total++;
        if ({nbr_mem1[0], nbr_mem1[11], nbr_mem1[22]} !== 96'd0)
            $display("FAIL bad_counts: got %0d %0d %0d want 0 0 0", nbr_mem1[0], nbr_mem1[11], nbr_mem1[22]);
        else passed++;
    endtask

    task automatic test_clear_only;
        logic [8:0]  addrs [8];
        logic [31:0] dis_or;
        int nw, first_w, last_w, done_cyc;
        bit busy_c1, err_c1;
        vertex_count = 5;
        face_count   = 0;
        nw = 0; first_w = -1; last_w = -1; done_cyc = -1; dis_or = '0;
        busy_c1 = 1'b0; err_c1 = 1'b1;
        @(negedge clk);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            if (cyc == 1) begin
                busy_c1 = busy1;
                err_c1  = err1;
            end
            if (nbr_en1 && nbr_we1 == 4'hF) begin
                if (nw < 8) addrs[nw] = nbr_a1;
                dis_or = dis_or | nbr_di1;
                if (first_w < 0) first_w = cyc;
                last_w = cyc;
                nw++;
            end
            if (done1 && done_cyc < 0) done_cyc = cyc;
            @(negedge clk);
        end
        total++;
        if ({busy_c1, err_c1} !== 2'b10)
            $display("FAIL clr_start_flags: busy/err at cycle1 got %b want 10", {busy_c1, err_c1});
        else passed++;
        total++;
        if (first_w != 1) $display("FAIL clr_first_write: cycle got %0d want 1", first_w); else passed++;
        total++;
        if (nw != 5) $display("FAIL clr_write_count: got %0d want 5", nw); else passed++;
        for (int i = 0; i < 5 && i < nw; i++) begin
            total++;
            if (addrs[i] !== 9'(11 * i))
                $display("FAIL clr_addr%0d: got %0d want %0d", i, addrs[i], 11 * i);
            else passed++;
        end
        total++;
        if (dis_or !== 32'd0) $display("FAIL clr_data: got %h want 0", dis_or); else passed++;
        total++;
        if (done_cyc != 6) $display("FAIL clr_done_cycle: got %0d want 6", done_cyc); else passed++;
        total++;
        if (busy1 !== 1'b0) $display("FAIL clr_busy_end: got %b want 0", busy1); else passed++;
    endtask

    task automatic test_reset_mid_pass;
        int pulses;
        bit bf;
        vertex_count = 4;
        face_count   = 2;
        load_face(4, 0, 0, 1, 2);
        load_face(4, 1, 0, 2, 3);
        bd_write(0, 32'h77, 1'b1);
        @(negedge clk);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        repeat (23) @(negedge clk);
        total++;
        if (busy1 !== 1'b1) $display("FAIL midrst_busy_before: got %b want 1", busy1); else passed++;
        rst_n = 1'b0;
        #1;
        total++;
        if ({busy1, done1, ovf1, err1, nbr_en1, nbr_we1, nbr_a1, nbr_di1, obj_en1, obj_a1} !== '0)
            $display("FAIL midrst_outputs: busy=%b done=%b nbr_en=%b nbr_we=%h nbr_a=%h obj_en=%b want 0",
                     busy1, done1, nbr_en1, nbr_we1, nbr_a1, obj_en1);
        else passed++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_pass(1'b0, pulses, bf);
        total++;
        if (pulses != 1) $display("FAIL midrst_done_pulses: got %0d want 1", pulses); else passed++;
        total++;
        if ({nbr_mem1[0], nbr_mem1[11], nbr_mem1[22], nbr_mem1[33]} !==
            {32'(EXP_SHARED), 32'd2, 32'(EXP_SHARED), 32'd2})
            $display("FAIL midrst_counts: got %0d %0d %0d %0d want %0d 2 %0d 2",
                     nbr_mem1[0], nbr_mem1[11], nbr_mem1[22], nbr_mem1[33], EXP_SHARED, EXP_SHARED);
        else passed++;
        total++;
        if (!(in_l1(0, EXP_SHARED, 1) && in_l1(0, EXP_SHARED, 2) && in_l1(0, EXP_SHARED, 3)))
            $display("FAIL midrst_list0: got %0d,%0d,%0d want {1,2,3}", nbr_mem1[1], nbr_mem1[2], nbr_mem1[3]);
        else passed++;
    endtask

    initial begin
        rst_n = 1'b0;
        start1 = 1'b0;
        start2 = 1'b0;
        vertex_count = '0;
        face_count = '0;
        bd_obj_we = 1'b0;
        bd_nbr_we1 = 1'b0;
        bd_a = '0;
        bd_d = '0;
        test_reset();
        test_triangle();
        test_shared_edge();
        test_overflow();
        test_bad_index();
        test_clear_only();
        test_reset_mid_pass();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/adjacency_builder.md
# adjacency_builder

Parametrised successor to the mesh averager front end. Given a triangle/polygon mesh in object RAM, it clears and then fills the per-vertex neighbour lists in neighbour RAM, one deduplicated entry per incident edge. It runs once per subdivision pass between mesh load and vertex averaging. Faces may have any fixed vertex count, and list depth and address width are generic.

## Interface
- ADDR_W, 9: RAM address width.
- MAX_NBR, 10: neighbour slots per vertex.
- FACE_VERTS, 3: vertex indices per face (≥3).
- VERT_WORDS, 3: object-RAM words per vertex record.
- clk  in  1  clock; all logic on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin a pass; sampled only in IDLE.
- vertex_count, face_count  in  32 each  mesh sizes, held stable while busy.
- RAM_OBJ_EN/WE/A/Di  out  1/4/ADDR_W/32  object RAM port (read-only use: WE=0, Di=0).
- RAM_OBJ_Do  in  32  object RAM read data.
- RAM_NBR_EN/WE/A/Di  out  1/4/ADDR_W/32  neighbour RAM port.
- RAM_NBR_Do  in  32  neighbour RAM read data.
- busy  out  1  pass in progress.
- done  out  1  one-cycle pulse at pass end.
- overflow  out  1  sticky: a neighbour was dropped because a list was full.
- err_index  out  1  sticky: a face held an index ≥ vertex_count.

## Operation
- Object layout: faces start at word 2 + VERT_WORDS·vertex_count; face f occupies FACE_VERTS consecutive words.
- Neighbour layout: vertex v record base B(v) = v·(MAX_NBR+1); word B is the count; words B+1..B+MAX_NBR are neighbour indices.
- States: IDLE → CLEAR → FACE_RD → EDGE_SEL → CNT_RD → SCAN → APPEND → CNT_WR → (EDGE_SEL | FACE_RD | DONE) → IDLE.
- CLEAR: write 0 to B(v) for v = 0..vertex_count−1, one write per cycle.
- FACE_RD: read FACE_VERTS indices into a register file. If any index is ≥ vertex_count, set err_index and skip the face.
- EDGE_SEL: for i = 0..FACE_VERTS−1, edge (a,b) = (idx[i], idx[(i+1) mod FACE_VERTS]). Insert b into list(a), then a into list(b). Skip degenerate edges (a==b).
- CNT_RD: read count c of the target list.
- SCAN: read slots 1..c and compare with the candidate. On a match, skip insertion.
- APPEND: if c == MAX_NBR, set overflow and drop. Otherwise write the candidate to slot c+1.
- CNT_WR: write c+1.
- Arithmetic: 32-bit counts and indices; addresses truncated to ADDR_W. Address fit is the caller's responsibility.
- vertex_count == 0: go straight to DONE, with no RAM writes. face_count == 0: CLEAR, then DONE.
- start while busy: ignored. start in IDLE clears overflow and err_index.

## Timing
- All outputs are registered. A read address driven from edge k is captured by the RAM at k+1, and Do is sampled by the block at k+2. Reads therefore take 2 cycles and are not pipelined.
- A write completes at the edge after it is driven: EN=1, WE=4'hF, A and Di valid for one cycle.
- start sampled high at edge k: busy=1 from k+1. The first CLEAR write is driven from k+1.
- done is high for exactly one cycle, and busy drops in the same cycle. Both flags hold their value until the next start.
- Reset values: busy=0, done=0, overflow=0, err_index=0, all EN=0, WE=0, A=0, Di=0, state IDLE.
- Reset mid-pass: immediate return to IDLE with the values above. RAM contents are left undefined.
- The object RAM port is idle (EN=0) outside FACE_RD reads.
- The neighbour RAM port is idle outside CLEAR/CNT_RD/SCAN/APPEND/CNT_WR accesses.

## Configuration
- ADJ_DEDUP_EN defined: SCAN runs as described, and each undirected edge appears once per list.
- ADJ_DEDUP_EN undefined: SCAN is removed and APPEND follows CNT_RD directly. Shared edges appear once per incident face. The overflow rule is unchanged.

## Test plan
- Single triangle (0,1,2), vertex_count=3, face_count=1 -> counts 2,2,2; list(0)={1,2}, list(1)={2,0}, list(2)={0,1}; done pulses once; flags 0.
- Faces (0,1,2),(0,2,3), vertex_count=4 -> with ADJ_DEDUP_EN: count(0)=3 {1,2,3}, count(2)=3 {0,1,3}. Without it: count(0)=4 and count(2)=4.
- MAX_NBR=2, faces (0,1,2),(0,2,3) -> count(0)=2 {1,2}, 3 dropped, overflow=1.
- Face (0,1,7), vertex_count=3 -> err_index=1; all counts 0 after CLEAR; done still pulses.
- face_count=0, vertex_count=5 -> 5 zero writes to addresses 0,11,22,33,44 (MAX_NBR=10); done follows the 5th write.
- rst_n low during SCAN -> outputs at reset values in the same cycle; a new start after release completes a correct pass.
